// File: rtl/piso_ser.sv
// Parallel-in / serial-out shifter with a valid/ready load port and a shift enable.
// Optional build macro PISO_SER_PARITY_EN appends an even-parity bit to every frame.
module piso_ser #(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  input  logic             ld_valid,
  output logic             ld_ready,
  input  logic             en,
  output logic             q,
  output logic             q_valid,
  output logic             done,
  output logic             busy,
  output logic             o_dbg_state
);

`ifdef PISO_SER_PARITY_EN
  localparam int FRAME_LEN = WIDTH + 1;
`else
  localparam int FRAME_LEN = WIDTH;
`endif
  localparam int CNT_W = $clog2(FRAME_LEN + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN);

  // Load handshake: a word is taken when ld_valid && ld_ready at a rising edge.
  // ld_ready is high in IDLE, or on the last frame bit while en is high, so
  // back-to-back frames run with no idle gap.
  typedef enum logic {S_IDLE = 1'b0, S_SHIFT = 1'b1} state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_sreg, w_sreg_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_q, w_q_nxt;
  logic             r_q_valid, w_q_valid_nxt;
  logic             r_done, w_done_nxt;
  logic             r_busy, w_busy_nxt;
`ifdef PISO_SER_PARITY_EN
  logic             r_par, w_par_nxt;
`endif
  logic             w_last;
  logic             w_load;

  function automatic logic f_head(input logic [WIDTH-1:0] v);
    return (MSB_FIRST != 0) ? v[WIDTH-1] : v[0];
  endfunction

  function automatic logic [WIDTH-1:0] f_shift(input logic [WIDTH-1:0] v);
    return (MSB_FIRST != 0) ? {v[WIDTH-2:0], 1'b0} : {1'b0, v[WIDTH-1:1]};
  endfunction

  // r_cnt is the 1-based index of the bit currently on q.
  assign w_last   = (r_state == S_SHIFT) && (r_cnt == LAST_CNT);
  assign ld_ready = (r_state == S_IDLE) || (w_last && en);
  assign w_load   = ld_valid && ld_ready;

  always_comb begin
    w_state_nxt   = r_state;
    w_sreg_nxt    = r_sreg;
    w_cnt_nxt     = r_cnt;
    w_q_nxt       = r_q;
    w_q_valid_nxt = r_q_valid;
    w_done_nxt    = r_done;
    w_busy_nxt    = r_busy;
`ifdef PISO_SER_PARITY_EN
    w_par_nxt     = r_par;
`endif
    if (w_load) begin
      w_state_nxt   = S_SHIFT;
      w_sreg_nxt    = f_shift(d);
      w_q_nxt       = f_head(d);
      w_cnt_nxt     = CNT_W'(1);
      w_q_valid_nxt = 1'b1;
      w_done_nxt    = 1'b0;
      w_busy_nxt    = 1'b1;
`ifdef PISO_SER_PARITY_EN
      w_par_nxt     = ^d;
`endif
    end else if ((r_state == S_SHIFT) && en) begin
      if (w_last) begin
        w_state_nxt   = S_IDLE;
        w_sreg_nxt    = '0;
        w_cnt_nxt     = '0;
        w_q_nxt       = 1'b0;
        w_q_valid_nxt = 1'b0;
        w_done_nxt    = 1'b0;
        w_busy_nxt    = 1'b0;
      end else begin
        w_cnt_nxt  = r_cnt + CNT_W'(1);
        w_done_nxt = (w_cnt_nxt == LAST_CNT);
        w_q_nxt    = f_head(r_sreg);
        w_sreg_nxt = f_shift(r_sreg);
`ifdef PISO_SER_PARITY_EN
        if (r_cnt == CNT_W'(WIDTH)) w_q_nxt = r_par;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_sreg    <= '0;
      r_cnt     <= '0;
      r_q       <= 1'b0;
      r_q_valid <= 1'b0;
      r_done    <= 1'b0;
      r_busy    <= 1'b0;
`ifdef PISO_SER_PARITY_EN
      r_par     <= 1'b0;
`endif
    end else begin
      r_state   <= w_state_nxt;
      r_sreg    <= w_sreg_nxt;
      r_cnt     <= w_cnt_nxt;
      r_q       <= w_q_nxt;
      r_q_valid <= w_q_valid_nxt;
      r_done    <= w_done_nxt;
      r_busy    <= w_busy_nxt;
`ifdef PISO_SER_PARITY_EN
      r_par     <= w_par_nxt;
`endif
    end
  end

  assign q           = r_q;
  assign q_valid     = r_q_valid;
  assign done        = r_done;
  assign busy        = r_busy;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_piso_ser.sv
// Bench for piso_ser: MSB-first and LSB-first instances share stimulus and are
// checked against a frame-queue reference model (parity honoured under PISO_SER_PARITY_EN).
module tb_piso_ser;

`ifdef PISO_SER_PARITY_EN
  localparam int FRAME_LEN = 9;
`else
  localparam int FRAME_LEN = 8;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] d = '0;
  logic       ld_valid = 1'b0;
  logic       en = 1'b0;

  logic rdy_m, q_m, qv_m, done_m, busy_m, st_m;
  logic rdy_l, q_l, qv_l, done_l, busy_l, st_l;

  piso_ser #(.WIDTH(8), .MSB_FIRST(1)) u_msb (
    .clk(clk), .rst_n(rst_n), .d(d), .ld_valid(ld_valid), .ld_ready(rdy_m),
    .en(en), .q(q_m), .q_valid(qv_m), .done(done_m), .busy(busy_m), .o_dbg_state(st_m)
  );

  piso_ser #(.WIDTH(8), .MSB_FIRST(0)) u_lsb (
    .clk(clk), .rst_n(rst_n), .d(d), .ld_valid(ld_valid), .ld_ready(rdy_l),
    .en(en), .q(q_l), .q_valid(qv_l), .done(done_l), .busy(busy_l), .o_dbg_state(st_l)
  );

  always #5 clk = ~clk;

  // Reference: each queue holds the remaining bits of the current frame, head = bit on q.
  logic exp_m_q[$];
  logic exp_l_q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  logic [7:0] seq_m, seq_l;
  int   done_cnt, qv_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void load_frame(input logic [7:0] w);
    exp_m_q.delete();
    exp_l_q.delete();
    for (int i = 0; i < 8; i++) begin
      exp_m_q.push_back(w[7-i]);
      exp_l_q.push_back(w[i]);
    end
`ifdef PISO_SER_PARITY_EN
    exp_m_q.push_back(^w);
    exp_l_q.push_back(^w);
`endif
  endfunction

  task automatic cycle(input logic rst, input logic lv, input logic [7:0] dd, input logic e);
    logic rdy_e;
    logic qv_e;
    @(negedge clk);
    rst_n = rst; ld_valid = lv; d = dd; en = e;
    #1;
    rdy_e = (exp_m_q.size() == 0) || ((exp_m_q.size() == 1) && e);
    if (rst) begin
      check("ld_ready_msb", rdy_m, rdy_e);
      check("ld_ready_lsb", rdy_l, rdy_e);
    end
    @(posedge clk);
    if (!rst) begin
      exp_m_q.delete();
      exp_l_q.delete();
    end else if (lv && rdy_e) begin
      load_frame(dd);
    end else if ((exp_m_q.size() > 0) && e) begin
      void'(exp_m_q.pop_front());
      void'(exp_l_q.pop_front());
    end
    #1;
    qv_e = (exp_m_q.size() > 0);
    check("q_valid_msb", qv_m, qv_e);
    check("q_valid_lsb", qv_l, qv_e);
    check("busy_msb", busy_m, qv_e);
    check("busy_lsb", busy_l, qv_e);
    check("state_msb", st_m, qv_e);
    check("done_msb", done_m, exp_m_q.size() == 1);
    check("done_lsb", done_l, exp_l_q.size() == 1);
    check("q_msb", q_m, qv_e ? exp_m_q[0] : 1'b0);
    check("q_lsb", q_l, qv_e ? exp_l_q[0] : 1'b0);
    seq_m = {seq_m[6:0], q_m};
    seq_l = {seq_l[6:0], q_l};
    if (done_m) done_cnt++;
    if (qv_m) qv_cnt++;
  endtask

  task automatic drain();
    repeat (FRAME_LEN + 1) cycle(1'b1, 1'b0, 8'h00, 1'b1);
  endtask

  initial begin
    repeat (3) cycle(1'b0, 1'b0, 8'h00, 1'b0);

    // 0xC1 with both bit orders, then the frame ends and q_valid drops
    done_cnt = 0;
    cycle(1'b1, 1'b1, 8'hC1, 1'b1);
    repeat (7) cycle(1'b1, 1'b0, 8'h00, 1'b1);
    check("seq_c1_msb", seq_m, 8'hC1);
    check("seq_c1_lsb", seq_l, 8'h83);
    check("done_c1_count", done_cnt, (FRAME_LEN == 8) ? 1 : 0);
    drain();

    // 0xFF then 0x00 back-to-back; ld_valid held high while not ready
    qv_cnt = 0; done_cnt = 0;
    cycle(1'b1, 1'b1, 8'hFF, 1'b1);
    repeat (FRAME_LEN - 1) cycle(1'b1, 1'b1, 8'h5A, 1'b1);
    cycle(1'b1, 1'b1, 8'h00, 1'b1);
    repeat (FRAME_LEN - 1) cycle(1'b1, 1'b0, 8'h00, 1'b1);
    check("b2b_valid_cycles", qv_cnt, 2 * FRAME_LEN);
    check("b2b_done_count", done_cnt, 2);
    drain();

    // 0xA5 with a three-cycle en stall after bit 2
    qv_cnt = 0; done_cnt = 0;
    cycle(1'b1, 1'b1, 8'hA5, 1'b1);
    cycle(1'b1, 1'b0, 8'h00, 1'b1);
    repeat (3) cycle(1'b1, 1'b1, 8'h3C, 1'b0);
    repeat (FRAME_LEN - 2) cycle(1'b1, 1'b0, 8'h00, 1'b1);
    check("stall_valid_cycles", qv_cnt, FRAME_LEN + 3);
    check("stall_done_count", done_cnt, 1);
    drain();

    // reset mid-frame wins over a simultaneous load and en
    done_cnt = 0;
    cycle(1'b1, 1'b1, 8'hA5, 1'b1);
    repeat (3) cycle(1'b1, 1'b0, 8'h00, 1'b1);
    cycle(1'b0, 1'b1, 8'hFF, 1'b1);
    cycle(1'b1, 1'b0, 8'h00, 1'b1);
    check("reset_no_done", done_cnt, 0);

    // load from IDLE with en low, then frozen, then released
    cycle(1'b1, 1'b1, 8'h3C, 1'b0);
    repeat (4) cycle(1'b1, 1'b0, 8'h00, 1'b0);
    drain();

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom_range(0, 49) != 0), ($urandom_range(0, 2) != 0),
            8'($urandom_range(0, 255)), ($urandom_range(0, 3) != 0));
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/piso_ser.md
PISO_SER -- requirements
Module: piso_ser

Interface
REQ-001 Parameter WIDTH, default 8, parallel word width in bits; SHALL be legal for WIDTH >= 2.
REQ-002 Parameter MSB_FIRST, default 1; 1 = bit WIDTH-1 shifted out first, 0 = bit 0 shifted out first.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 d  input  WIDTH  parallel word, sampled only on a load handshake.
REQ-006 ld_valid  input  1  producer offers d for loading.
REQ-007 ld_ready  output  1  block accepts d this cycle.
REQ-008 en  input  1  shift enable; 0 freezes the frame in progress.
REQ-009 q  output  1  serial data bit, registered.
REQ-010 q_valid  output  1  q carries a frame bit this cycle, registered.
REQ-011 done  output  1  q carries the last bit of the frame, registered.
REQ-012 busy  output  1  a frame is in progress, registered.

Function
REQ-013 States SHALL be IDLE and SHIFT; a load occurs when ld_valid and ld_ready are both 1 at a rising edge.
REQ-014 ld_ready SHALL be combinational: 1 in IDLE, or 1 in SHIFT when the current bit is the last of the frame and en = 1; else 0.
REQ-015 A load SHALL capture d into the shift register, enter SHIFT, and present the first bit on q with q_valid = 1 and busy = 1 in the next cycle (one-cycle latency).
REQ-016 In SHIFT with en = 1, each edge SHALL advance q to the next bit in MSB_FIRST order; a bit counter sized clog2(WIDTH+1) SHALL track bits sent.
REQ-017 In SHIFT with en = 0, q, q_valid, done, busy, counter and shift register SHALL hold.
REQ-018 done SHALL be 1 exactly while the last frame bit is on q, alongside q_valid = 1.
REQ-019 After the last bit with en = 1 and no load: return to IDLE; q_valid, done, busy SHALL be 0 and q SHALL be 0 the next cycle.
REQ-020 A load on the last-bit cycle SHALL start the next frame with no idle gap: the next cycle shows its first bit, q_valid = 1, done = 0.
REQ-021 ld_valid outside ld_ready SHALL be ignored; d SHALL not affect any frame in progress.
REQ-022 en SHALL not gate a load from IDLE.

Reset
REQ-023 rst_n = 0 at an edge SHALL force IDLE, q = 0, q_valid = 0, done = 0, busy = 0, counter and shift register = 0.
REQ-024 Reset mid-frame SHALL abort the frame without asserting done; ld_ready SHALL be 1 in the first cycle after reset release.
REQ-025 rst_n = 0 SHALL take priority over load and en.

Configuration
REQ-026 Macro PISO_SER_PARITY_EN: when defined, an even-parity bit (XOR of the captured word) SHALL follow the last data bit, frame length WIDTH+1, done asserted with the parity bit.
REQ-027 When PISO_SER_PARITY_EN is undefined, frame length SHALL be WIDTH, done SHALL be asserted with the last data bit, and no parity logic SHALL exist.

Verification (WIDTH=8, parity disabled unless stated)
REQ-028 MSB_FIRST=1, load 0xC1, en=1 -> q = 1,1,0,0,0,0,0,1 on cycles 1..8, done only on cycle 8, q_valid=0 on cycle 9.
REQ-029 MSB_FIRST=0, load 0xC1 -> q = 1,0,0,0,0,0,1,1, done on 8th bit.
REQ-030 Load 0xFF then 0x00 on the last-bit cycle -> 16 contiguous q_valid cycles, q = eight 1s then eight 0s, done on cycles 8 and 16.
REQ-031 Load 0xA5, en=0 for 3 cycles after bit 2 -> q holds 0 for 3 extra cycles, then 1,0,0,1,0,1; done on 11th valid cycle.
REQ-032 Load 0xA5, rst_n=0 after bit 4 -> next cycle all outputs 0, no done, ld_ready=1.
REQ-033 PISO_SER_PARITY_EN defined, load 0x07 -> 8 data bits then parity bit 1, done on 9th bit.
